// File: rtl/npu_axil_pkg.sv
// npu_axil_pkg: register map offsets, window bases, response codes and bit
// positions shared by the NPU AXI4-Lite register block and its decoder.
package npu_axil_pkg;

  localparam logic [11:0] OFF_CTRL       = 12'h000;
  localparam logic [11:0] OFF_STATUS     = 12'h004;
  localparam logic [11:0] OFF_CONFIG     = 12'h008;
  localparam logic [11:0] OFF_INT_STATUS = 12'h00C;
  localparam logic [11:0] OFF_INT_EN     = 12'h010;

  localparam logic [11:0] BASE_WGT = 12'h100;
  localparam logic [11:0] BASE_IN  = 12'h200;
  localparam logic [11:0] BASE_OUT = 12'h300;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_START_BIT  = 1;
  localparam int unsigned CFG_W           = 9;
  localparam int unsigned CFG_RELU_BIT    = 8;
  localparam int unsigned INT_DONE_BIT    = 0;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  // Word offset inside a 256-byte window
  localparam int unsigned WIN_IDX_W = 6;

  typedef enum logic [3:0] {
    RG_NONE,
    RG_CTRL,
    RG_STATUS,
    RG_CONFIG,
    RG_INT_STATUS,
    RG_INT_EN,
    RG_WGT,
    RG_IN,
    RG_OUT
  } region_t;

endpackage

// File: rtl/npu_axil_decode.sv
// npu_axil_decode: combinational byte offset -> {region, window index, legal}.
// One instance serves the write address channel, one the read address channel.
module npu_axil_decode
  import npu_axil_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = 8
)(
  input  logic [11:0]          addr,
  output region_t              region,
  output logic [WIN_IDX_W-1:0] index,
  output logic                 legal
);

  logic [31:0] word;

  assign index = addr[7:2];
  assign word  = 32'(addr[7:2]);

  // Classify the offset and range-check window indices
  always_comb begin
    region = RG_NONE;
    legal  = 1'b0;
    case (addr[11:8])
      4'h0: begin
        legal = 1'b1;
        case (addr[7:2])
          OFF_CTRL[7:2]:       region = RG_CTRL;
          OFF_STATUS[7:2]:     region = RG_STATUS;
          OFF_CONFIG[7:2]:     region = RG_CONFIG;
          OFF_INT_STATUS[7:2]: region = RG_INT_STATUS;
          OFF_INT_EN[7:2]:     region = RG_INT_EN;
          default: begin
            region = RG_NONE;
            legal  = 1'b0;
          end
        endcase
      end
      BASE_WGT[11:8]: begin
        region = RG_WGT;
        legal  = (word < 32'(MATRIX_SIZE * MATRIX_SIZE));
      end
      BASE_IN[11:8]: begin
        region = RG_IN;
        legal  = (word < 32'(MATRIX_SIZE));
      end
      BASE_OUT[11:8]: begin
        region = RG_OUT;
        legal  = (word < 32'(MATRIX_SIZE));
      end
      default: begin
        region = RG_NONE;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/npu_axil_regs.sv
// npu_axil_regs: AXI4-Lite responder for the NPU control plane.
// Optional build macro NPU_AXIL_WSTRB_EN: CONFIG/INT_EN honour wstrb per byte
// and WEIGHT/INPUT writes require wstrb[1:0] == 2'b11.
module npu_axil_regs
  import npu_axil_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MATRIX_SIZE    = 8
)(
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [AXI_ADDR_WIDTH-1:0]             s_axi_awaddr,
  input  logic [2:0]                            s_axi_awprot,
  input  logic                                  s_axi_awvalid,
  output logic                                  s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]             s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]           s_axi_wstrb,
  input  logic                                  s_axi_wvalid,
  output logic                                  s_axi_wready,
  output logic [1:0]                            s_axi_bresp,
  output logic                                  s_axi_bvalid,
  input  logic                                  s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]             s_axi_araddr,
  input  logic [2:0]                            s_axi_arprot,
  input  logic                                  s_axi_arvalid,
  output logic                                  s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]             s_axi_rdata,
  output logic [1:0]                            s_axi_rresp,
  output logic                                  s_axi_rvalid,
  input  logic                                  s_axi_rready,
  output logic                                  core_start,
  input  logic                                  core_busy,
  input  logic                                  core_done,
  output logic [7:0]                            cfg_size,
  output logic                                  cfg_relu,
  output logic                                  wgt_we,
  output logic [$clog2(MATRIX_SIZE*MATRIX_SIZE)-1:0] wgt_idx,
  output logic                                  in_we,
  output logic [$clog2(MATRIX_SIZE)-1:0]        in_idx,
  output logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]     out_vec,
  output logic                                  interrupt
);

  localparam int unsigned WIDX_W = $clog2(MATRIX_SIZE * MATRIX_SIZE);
  localparam int unsigned IIDX_W = $clog2(MATRIX_SIZE);

  region_t                aw_region, ar_region;
  logic [WIN_IDX_W-1:0]   aw_index, ar_index;
  logic                   aw_legal, ar_legal;

  logic                   wr_acc, rd_acc;
  logic [CFG_W-1:0]       cfg_q, cfg_next;
  logic                   int_en_q, int_en_next;
  logic                   int_status_q;
  logic                   w1c, wgt_fire, in_fire, start_fire;
  logic [1:0]             wr_resp, rd_resp;
  logic [AXI_DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0]  out_elem;
  logic                   unused_ok;

  npu_axil_decode #(.MATRIX_SIZE(MATRIX_SIZE)) u_aw_decode (
    .addr   (s_axi_awaddr[11:0]),
    .region (aw_region),
    .index  (aw_index),
    .legal  (aw_legal)
  );

  npu_axil_decode #(.MATRIX_SIZE(MATRIX_SIZE)) u_ar_decode (
    .addr   (s_axi_araddr[11:0]),
    .region (ar_region),
    .index  (ar_index),
    .legal  (ar_legal)
  );

  // AW and W are only taken together; an open B response blocks the next write
  assign wr_acc        = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
  assign s_axi_awready = wr_acc;
  assign s_axi_wready  = wr_acc;
  assign rd_acc        = s_axi_arvalid & ~s_axi_rvalid;
  assign s_axi_arready = rd_acc;

  assign cfg_size = cfg_q[7:0];
  assign cfg_relu = cfg_q[CFG_RELU_BIT];

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                       s_axi_wstrb, s_axi_wdata};

  // Decode the accepted write into register updates, strobes and a response
  always_comb begin
    wr_resp     = RESP_OKAY;
    cfg_next    = cfg_q;
    int_en_next = int_en_q;
    w1c         = 1'b0;
    wgt_fire    = 1'b0;
    in_fire     = 1'b0;
    start_fire  = 1'b0;
    if (!aw_legal) begin
      wr_resp = RESP_SLVERR;
    end else begin
      case (aw_region)
        RG_CTRL:       start_fire = s_axi_wdata[CTRL_START_BIT] & ~core_busy;
        RG_CONFIG: begin
`ifdef NPU_AXIL_WSTRB_EN
          if (s_axi_wstrb[0]) cfg_next[7:0]        = s_axi_wdata[7:0];
          if (s_axi_wstrb[1]) cfg_next[CFG_RELU_BIT] = s_axi_wdata[CFG_RELU_BIT];
`else
          cfg_next = s_axi_wdata[CFG_W-1:0];
`endif
        end
        RG_INT_STATUS: w1c = s_axi_wdata[INT_DONE_BIT];
        RG_INT_EN: begin
`ifdef NPU_AXIL_WSTRB_EN
          if (s_axi_wstrb[0]) int_en_next = s_axi_wdata[0];
`else
          int_en_next = s_axi_wdata[0];
`endif
        end
        RG_WGT, RG_IN: begin
          if (core_busy) begin
            wr_resp = RESP_SLVERR;
`ifdef NPU_AXIL_WSTRB_EN
          end else if (s_axi_wstrb[1:0] != 2'b11) begin
            wr_resp = RESP_SLVERR;
`endif
          end else if (aw_region == RG_WGT) begin
            wgt_fire = 1'b1;
          end else begin
            in_fire = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data mux; write-only regions read as zero
  always_comb begin
    rd_resp  = RESP_OKAY;
    rd_val   = '0;
    out_elem = out_vec[ar_index[IIDX_W-1:0] * DATA_WIDTH +: DATA_WIDTH];
    if (!ar_legal) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (ar_region)
        RG_STATUS: begin
          rd_val[STATUS_BUSY_BIT] = core_busy;
          rd_val[STATUS_DONE_BIT] = int_status_q;
        end
        RG_CONFIG:     rd_val[CFG_W-1:0]   = cfg_q;
        RG_INT_STATUS: rd_val[INT_DONE_BIT] = int_status_q;
        RG_INT_EN:     rd_val[0]            = int_en_q;
        RG_OUT:        rd_val = AXI_DATA_WIDTH'($signed(out_elem));
        default: ;
      endcase
    end
  end

  // Write channel: apply effects one cycle after accept, hold B until bready
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      cfg_q        <= '0;
      int_en_q     <= 1'b0;
      wgt_we       <= 1'b0;
      in_we        <= 1'b0;
      core_start   <= 1'b0;
      wgt_idx      <= '0;
      in_idx       <= '0;
      wr_data      <= '0;
    end else begin
      wgt_we     <= 1'b0;
      in_we      <= 1'b0;
      core_start <= 1'b0;
      if (wr_acc) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
        cfg_q        <= cfg_next;
        int_en_q     <= int_en_next;
        wgt_we       <= wgt_fire;
        in_we        <= in_fire;
        core_start   <= start_fire;
        if (wgt_fire || in_fire) wr_data <= s_axi_wdata[DATA_WIDTH-1:0];
        if (wgt_fire) wgt_idx <= aw_index[WIDX_W-1:0];
        if (in_fire)  in_idx  <= aw_index[IIDX_W-1:0];
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Done flag (set beats W1C) and the registered interrupt level
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      int_status_q <= 1'b0;
      interrupt    <= 1'b0;
    end else begin
      int_status_q <= core_done | (int_status_q & ~(wr_acc & w1c));
      interrupt    <= int_status_q & int_en_q;
    end
  end

  // Read channel: capture data at accept, hold R until rready
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (rd_acc) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_val;
      s_axi_rresp  <= rd_resp;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule
